// File: rtl/enc_code_capture.sv
// Debounced capture of encoder codes: accepts a code once it has been stable for
// STABLE_CYCLES samples, drops back-to-back duplicates and keeps a 4-deep history.
module enc_code_capture #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  code,
  input  logic        code_valid,
  input  logic        clear,
  output logic [3:0]  last_code,
  output logic [15:0] history,
  output logic [2:0]  hist_count,
  output logic [7:0]  capture_count,
  output logic        new_code,
  output logic        busy
);

  localparam int unsigned HIST_DEPTH = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [2:0] HIST_FULL = 3'(HIST_DEPTH);
  localparam logic [7:0] CAP_MAX   = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [3:0]       cand, cand_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             accept_c;

  logic [3:0]  last_code_nxt;
  logic [15:0] history_nxt;
  logic [2:0]  hist_count_nxt;
  logic [7:0]  capture_count_nxt;
  logic        new_code_nxt;
  logic        busy_nxt;

  // State, candidate/counter and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cand          <= 4'd0;
      cnt           <= '0;
      last_code     <= 4'd0;
      history       <= 16'd0;
      hist_count    <= 3'd0;
      capture_count <= 8'd0;
      new_code      <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nxt;
      cand          <= cand_nxt;
      cnt           <= cnt_nxt;
      last_code     <= last_code_nxt;
      history       <= history_nxt;
      hist_count    <= hist_count_nxt;
      capture_count <= capture_count_nxt;
      new_code      <= new_code_nxt;
      busy          <= busy_nxt;
    end
  end

  // Next-state: stability counting; any change or dropped valid restarts the count
  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    accept_c  = 1'b0;
    if (clear) begin
      state_nxt = IDLE;
      cand_nxt  = 4'd0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (code_valid) begin
            state_nxt = COUNT;
            cand_nxt  = code;
            cnt_nxt   = CNT_ONE;
          end
        end
        COUNT: begin
          if (!code_valid) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (code != cand) begin
            cand_nxt = code;
            cnt_nxt  = CNT_ONE;
          end else if (cnt == CNT_LAST) begin
            accept_c  = 1'b1;
            state_nxt = HOLD;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        HOLD: begin
          if (!code_valid) begin
            state_nxt = IDLE;
          end else if (code != cand) begin
            state_nxt = COUNT;
            cand_nxt  = code;
            cnt_nxt   = CNT_ONE;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs: an accept of a code equal to last_code is swallowed as a duplicate
  always_comb begin
    last_code_nxt     = last_code;
    history_nxt       = history;
    hist_count_nxt    = hist_count;
    capture_count_nxt = capture_count;
    new_code_nxt      = 1'b0;
    busy_nxt          = (state_nxt != IDLE);
    if (clear) begin
      last_code_nxt     = 4'd0;
      history_nxt       = 16'd0;
      hist_count_nxt    = 3'd0;
      capture_count_nxt = 8'd0;
      busy_nxt          = 1'b0;
    end else if (accept_c && ((hist_count == 3'd0) || (cand != last_code))) begin
      history_nxt   = {history[11:0], cand};
      last_code_nxt = cand;
      new_code_nxt  = 1'b1;
      if (hist_count != HIST_FULL) begin
        hist_count_nxt = hist_count + 3'd1;
      end
      if (capture_count != CAP_MAX) begin
        capture_count_nxt = capture_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_enc_code_capture.sv
// Directed self-checking bench for enc_code_capture with STABLE_CYCLES=4.
module tb_enc_code_capture;

  logic        clock;
  logic        reset_n;
  logic [3:0]  code;
  logic        code_valid;
  logic        clear;
  logic [3:0]  last_code;
  logic [15:0] history;
  logic [2:0]  hist_count;
  logic [7:0]  capture_count;
  logic        new_code;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int pulses;
  int first_pulse;
  int total_pulses;

  enc_code_capture #(.STABLE_CYCLES(4), .CNT_W(16)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .code          (code),
    .code_valid    (code_valid),
    .clear         (clear),
    .last_code     (last_code),
    .history       (history),
    .hist_count    (hist_count),
    .capture_count (capture_count),
    .new_code      (new_code),
    .busy          (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive inputs for n clock edges, counting new_code pulses seen after each edge
  task automatic apply(input logic [3:0] c, input logic v, input int n);
    code       = c;
    code_valid = v;
    pulses      = 0;
    first_pulse = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      if (new_code) begin
        pulses++;
        if (first_pulse == 0) first_pulse = i + 1;
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".last"},  32'(last_code), 32'h0);
    check({tag, ".hist"},  32'(history), 32'h0);
    check({tag, ".hcnt"},  32'(hist_count), 32'h0);
    check({tag, ".cap"},   32'(capture_count), 32'h0);
    check({tag, ".new"},   32'(new_code), 32'h0);
    check({tag, ".busy"},  32'(busy), 32'h0);
  endtask

  initial begin
    reset_n    = 1'b0;
    code       = 4'd0;
    code_valid = 1'b0;
    clear      = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_zero("reset");
    reset_n = 1'b1;

    // Code 5 held 6 clocks: one pulse after the 4th edge
    apply(4'd5, 1'b1, 6);
    check("t1.pulses", 32'(pulses), 32'd1);
    check("t1.first", 32'(first_pulse), 32'd4);
    check("t1.last", 32'(last_code), 32'h5);
    check("t1.hist", 32'(history), 32'h0005);
    check("t1.hcnt", 32'(hist_count), 32'd1);
    check("t1.cap", 32'(capture_count), 32'd1);
    check("t1.busy", 32'(busy), 32'd1);

    // 3 for only 3 clocks is rejected; 7 accepted on its 4th edge
    apply(4'd3, 1'b1, 3);
    check("t2.pulses3", 32'(pulses), 32'd0);
    apply(4'd7, 1'b1, 4);
    check("t2.pulses7", 32'(pulses), 32'd1);
    check("t2.first7", 32'(first_pulse), 32'd4);
    check("t2.last", 32'(last_code), 32'h7);
    check("t2.hist", 32'(history), 32'h0057);
    check("t2.cap", 32'(capture_count), 32'd2);

    // Duplicate suppression across a dropped valid
    apply(4'd9, 1'b1, 4);
    check("t3.pulses9", 32'(pulses), 32'd1);
    check("t3.hist9", 32'(history), 32'h0579);
    apply(4'd9, 1'b0, 1);
    check("t3.busy_idle", 32'(busy), 32'd0);
    apply(4'd9, 1'b1, 4);
    check("t3.dup_pulses", 32'(pulses), 32'd0);
    check("t3.dup_hist", 32'(history), 32'h0579);
    check("t3.dup_cap", 32'(capture_count), 32'd3);
    check("t3.dup_busy", 32'(busy), 32'd1);
    apply(4'd2, 1'b1, 4);
    check("t3.pulses2", 32'(pulses), 32'd1);
    check("t3.last2", 32'(last_code), 32'h2);
    check("t3.hist2", 32'(history), 32'h5792);
    check("t3.hcnt2", 32'(hist_count), 32'd4);

    // Synchronous clear, then five accepts in a row
    clear = 1'b1;
    apply(4'd2, 1'b1, 1);
    clear = 1'b0;
    check_zero("clr");
    total_pulses = 0;
    for (int k = 1; k <= 5; k++) begin
      apply(4'(k), 1'b1, 4);
      total_pulses += pulses;
    end
    check("t4.pulses", 32'(total_pulses), 32'd5);
    check("t4.hist", 32'(history), 32'h2345);
    check("t4.hcnt", 32'(hist_count), 32'd4);
    check("t4.cap", 32'(capture_count), 32'd5);

    // Async reset in the middle of a count
    apply(4'd6, 1'b1, 2);
    reset_n = 1'b0;
    #2;
    check_zero("arst");
    #1;
    reset_n = 1'b1;
    apply(4'd6, 1'b1, 3);
    check("t5.no_early", 32'(pulses), 32'd0);
    apply(4'd6, 1'b1, 1);
    check("t5.pulse", 32'(pulses), 32'd1);
    check("t5.last", 32'(last_code), 32'h6);
    check("t5.hist", 32'(history), 32'h0006);
    check("t5.cap", 32'(capture_count), 32'd1);

    // Clear on the edge of a pending accept wins
    apply(4'd8, 1'b1, 3);
    check("t6.pre", 32'(pulses), 32'd0);
    clear = 1'b1;
    apply(4'd8, 1'b1, 1);
    clear = 1'b0;
    check_zero("t6");

    // 260 alternating accepts saturate capture_count
    total_pulses = 0;
    for (int k = 0; k < 260; k++) begin
      apply((k % 2 == 1) ? 4'd2 : 4'd1, 1'b1, 4);
      total_pulses += pulses;
    end
    check("t7.pulses", 32'(total_pulses), 32'd260);
    check("t7.cap", 32'(capture_count), 32'd255);
    check("t7.hcnt", 32'(hist_count), 32'd4);
    check("t7.hist", 32'(history), 32'h1212);
    check("t7.last", 32'(last_code), 32'h2);

    // Code 0 is accepted like any other value
    apply(4'd0, 1'b1, 4);
    check("t8.pulse", 32'(pulses), 32'd1);
    check("t8.last", 32'(last_code), 32'h0);
    check("t8.hist", 32'(history), 32'h2120);
    check("t8.cap", 32'(capture_count), 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
